// File: rtl/mc_pkg.sv
// Shared microcontroller definitions: opcode constants, opcode classes and
// the fetch sequencer state encoding. Execution FSMs import the same opcodes.
package mc_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_ALUI_ADD = 4'h1;
    localparam logic [3:0] OP_ALUI_SUB = 4'h2;
    localparam logic [3:0] OP_HALT     = 4'hF;
    localparam logic [3:0] OP_ILL_LO   = 4'hB;
    localparam logic [3:0] OP_ILL_HI   = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP     = 2'd0,
        CLS_EXEC    = 2'd1,
        CLS_HALT    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        if (op == OP_NOP) begin
            cls = CLS_NOP;
        end else if (op == OP_HALT) begin
            cls = CLS_HALT;
        end else if ((op >= OP_ILL_LO) && (op <= OP_ILL_HI)) begin
            cls = CLS_ILLEGAL;
        end else begin
            cls = CLS_EXEC;
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bus bundle between the fetch sequencer, program memory, PC register and
// the execution FSMs.
interface instr_fetch_seq_if #(
    parameter int ADDR_W = 8
);
    import mc_pkg::*;

    logic                run;
    logic [ADDR_W-1:0]   pc_addr;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic [INSTR_W-1:0]  mem_rdata;
    logic                mem_valid;
    logic [INSTR_W-1:0]  fullBitNum;
    logic                done;
    logic                nop_pc_inc;
    logic                busy;
    logic                halted;
    logic                fault;

    modport master (
        input  run, pc_addr, mem_rdata, mem_valid, done,
        output mem_addr, mem_rd, fullBitNum, nop_pc_inc, busy, halted, fault
    );

    modport slave (
        output run, pc_addr, mem_rdata, mem_valid, done,
        input  mem_addr, mem_rd, fullBitNum, nop_pc_inc, busy, halted, fault
    );

endinterface

// File: rtl/exec_watchdog.sv
// EXEC-phase cycle counter; expired flags the cycle whose increment would
// reach TIMEOUT, so the sequencer can fault on that same edge.
module exec_watchdog #(
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_r;

    // Cycle counter; clear dominates enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en && (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/dispatch sequencer: fetch, latch, present to the execution
// FSMs until done, then one all-zero flush cycle before the next fetch.
module instr_fetch_seq
    import mc_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 31
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_seq_if.master  bus
);

    state_e              state_r,  state_n_s;
    logic [INSTR_W-1:0]  ir_r,     ir_n_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_n_s;
    logic                mem_rd_r, mem_rd_n_s;
    logic [INSTR_W-1:0]  fbn_r,    fbn_n_s;
    logic                nop_r,    nop_n_s;
    logic                busy_r,   busy_n_s;
    logic                halted_r, halted_n_s;
    logic                fault_r,  fault_n_s;
    logic                expired_s;
    logic                in_exec_s;

    assign in_exec_s = (state_r == ST_EXEC);

    exec_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_exec_s),
        .en      (in_exec_s),
        .expired (expired_s)
    );

    // Next-state and next-output decode; outputs derive from the next state so
    // every port is driven straight from a flop.
    always_comb begin
        state_n_s    = state_r;
        ir_n_s       = ir_r;
        mem_addr_n_s = mem_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.run) state_n_s = ST_FETCH;
                else         state_n_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.mem_valid) begin
                    ir_n_s    = bus.mem_rdata;
                    state_n_s = ST_DECODE;
                end else begin
                    state_n_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (op_class(ir_r[15:12]))
                    CLS_NOP:  state_n_s = ST_FLUSH;
                    CLS_EXEC: state_n_s = ST_EXEC;
                    CLS_HALT: state_n_s = ST_HALT;
                    default:  state_n_s = ST_FAULT;
                endcase
            end
            ST_EXEC: begin
                if (bus.done)     state_n_s = ST_FLUSH;
                else if (expired_s) state_n_s = ST_FAULT;
                else              state_n_s = ST_EXEC;
            end
            ST_FLUSH: begin
                if (bus.run) state_n_s = ST_FETCH;
                else         state_n_s = ST_IDLE;
            end
            ST_HALT:  state_n_s = ST_HALT;
            ST_FAULT: state_n_s = ST_FAULT;
            default:  state_n_s = ST_FAULT;
        endcase

        if (state_n_s == ST_FETCH) begin
            mem_addr_n_s = bus.pc_addr;
        end else begin
            mem_addr_n_s = mem_addr_r;
        end

        mem_rd_n_s = (state_n_s == ST_FETCH);
        fbn_n_s    = (state_n_s == ST_EXEC) ? ir_n_s : {INSTR_W{1'b0}};
        nop_n_s    = (state_n_s == ST_DECODE) && (op_class(ir_n_s[15:12]) == CLS_NOP);
        busy_n_s   = (state_n_s == ST_FETCH) || (state_n_s == ST_DECODE) ||
                     (state_n_s == ST_EXEC)  || (state_n_s == ST_FLUSH);
        halted_n_s = (state_n_s == ST_HALT);
        fault_n_s  = (state_n_s == ST_FAULT);
    end

    // State, instruction register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ir_r       <= {INSTR_W{1'b0}};
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_rd_r   <= 1'b0;
            fbn_r      <= {INSTR_W{1'b0}};
            nop_r      <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            ir_r       <= ir_n_s;
            mem_addr_r <= mem_addr_n_s;
            mem_rd_r   <= mem_rd_n_s;
            fbn_r      <= fbn_n_s;
            nop_r      <= nop_n_s;
            busy_r     <= busy_n_s;
            halted_r   <= halted_n_s;
            fault_r    <= fault_n_s;
        end
    end

    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_rd     = mem_rd_r;
    assign bus.fullBitNum = fbn_r;
    assign bus.nop_pc_inc = nop_r;
    assign bus.busy       = busy_r;
    assign bus.halted     = halted_r;
    assign bus.fault      = fault_r;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed self-checking bench for instr_fetch_seq with a scoreboard of
// instruction words expected on fullBitNum.
module tb_instr_fetch_seq;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [7:0]  pc_val;
    logic [15:0] exp_q[$];

    instr_fetch_seq_if #(.ADDR_W(8)) bus ();

    instr_fetch_seq #(.ADDR_W(8), .TIMEOUT(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word from memory after 'waits' wait states; ends in DECODE.
    task automatic serve(input logic [15:0] word, input int waits);
        logic [3:0] op;
        op = word[15:12];
        for (int i = 0; i < waits; i++) begin
            bus.mem_valid = 1'b0;
            bus.mem_rdata = 16'hB0A5;
            bus.done      = (i == 0);
            chk("fetch_wait_rd", {31'd0, bus.mem_rd}, 32'd1);
            chk("fetch_wait_addr", {24'd0, bus.mem_addr}, {24'd0, pc_val});
            step();
        end
        bus.done = 1'b0;
        chk("fetch_rd", {31'd0, bus.mem_rd}, 32'd1);
        chk("fetch_addr", {24'd0, bus.mem_addr}, {24'd0, pc_val});
        bus.mem_valid = 1'b1;
        bus.mem_rdata = word;
        if ((op >= 4'h1) && (op <= 4'hA)) exp_q.push_back(word);
        step();
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 16'hB0A5;
        chk("decode_busy", {31'd0, bus.busy}, 32'd1);
        chk("decode_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        chk("decode_rd", {31'd0, bus.mem_rd}, 32'd0);
    endtask

    // DECODE -> EXEC; the word on fullBitNum must match the scoreboard head.
    task automatic exec_enter();
        logic [15:0] exp;
        step();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("exec_fbn", {16'd0, bus.fullBitNum}, {16'd0, exp});
        chk("exec_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.run       = 1'b0;
        pc_val        = 8'h10;
        bus.pc_addr   = pc_val;
        bus.mem_rdata = 16'h0000;
        bus.mem_valid = 1'b0;
        bus.done      = 1'b0;
        step();
        step();
        chk("rst_addr",   {24'd0, bus.mem_addr}, 32'd0);
        chk("rst_rd",     {31'd0, bus.mem_rd}, 32'd0);
        chk("rst_fbn",    {16'd0, bus.fullBitNum}, 32'd0);
        chk("rst_nop",    {31'd0, bus.nop_pc_inc}, 32'd0);
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_fault",  {31'd0, bus.fault}, 32'd0);

        // Zero-wait ALU immediate, done in EXEC cycle 9: 12-cycle instruction.
        rst = 1'b0;
        bus.run = 1'b1;
        step();
        serve(16'h1046, 0);
        exec_enter();
        for (int k = 1; k < 9; k++) begin
            chk("exec_hold", {16'd0, bus.fullBitNum}, 32'h1046);
            step();
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("flush_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        chk("flush_busy", {31'd0, bus.busy}, 32'd1);
        chk("flush_rd", {31'd0, bus.mem_rd}, 32'd0);
        pc_val = 8'h11;
        bus.pc_addr = pc_val;
        step();
        chk("refetch_rd", {31'd0, bus.mem_rd}, 32'd1);

        // Three wait states with garbage data and a spurious done.
        serve(16'h2005, 3);
        exec_enter();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("flush2_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        pc_val = 8'h12;
        bus.pc_addr = pc_val;
        step();

        // NOP: single nop_pc_inc pulse, no EXEC.
        serve(16'h0000, 0);
        chk("nop_pulse", {31'd0, bus.nop_pc_inc}, 32'd1);
        step();
        chk("nop_flush_pulse", {31'd0, bus.nop_pc_inc}, 32'd0);
        chk("nop_flush_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        chk("nop_flush_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("nop_refetch_rd", {31'd0, bus.mem_rd}, 32'd1);

        // run dropped mid-EXEC: finish through FLUSH, then IDLE.
        serve(16'h1046, 0);
        exec_enter();
        bus.run = 1'b0;
        step();
        step();
        chk("rundrop_exec", {16'd0, bus.fullBitNum}, 32'h1046);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("rundrop_flush_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("rundrop_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("rundrop_idle_rd", {31'd0, bus.mem_rd}, 32'd0);
        step();
        chk("rundrop_idle_stay", {31'd0, bus.mem_rd}, 32'd0);

        // done in the timeout cycle wins.
        bus.run = 1'b1;
        step();
        serve(16'h2005, 0);
        exec_enter();
        for (int k = 1; k < 31; k++) step();
        chk("tmo_done_c31_busy", {31'd0, bus.busy}, 32'd1);
        chk("tmo_done_c31_fbn", {16'd0, bus.fullBitNum}, 32'h2005);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("tmo_done_fault", {31'd0, bus.fault}, 32'd0);
        chk("tmo_done_flush_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        chk("tmo_done_flush_busy", {31'd0, bus.busy}, 32'd1);
        step();

        // No done: fault after 31 EXEC cycles.
        serve(16'h1046, 0);
        exec_enter();
        for (int k = 1; k < 31; k++) step();
        chk("tmo_c31_fault", {31'd0, bus.fault}, 32'd0);
        chk("tmo_c31_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("tmo_fault", {31'd0, bus.fault}, 32'd1);
        chk("tmo_fault_busy", {31'd0, bus.busy}, 32'd0);
        chk("tmo_fault_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        step();
        step();
        step();
        chk("tmo_fault_sticky", {31'd0, bus.fault}, 32'd1);
        chk("tmo_fault_rd", {31'd0, bus.mem_rd}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("tmo_rst_fault", {31'd0, bus.fault}, 32'd0);
        step();

        // Illegal opcode.
        serve(16'hB000, 0);
        chk("ill_decode_fault", {31'd0, bus.fault}, 32'd0);
        step();
        chk("ill_fault", {31'd0, bus.fault}, 32'd1);
        chk("ill_busy", {31'd0, bus.busy}, 32'd0);
        step();
        step();
        chk("ill_sticky", {31'd0, bus.fault}, 32'd1);
        bus.run = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ill_rst_fault", {31'd0, bus.fault}, 32'd0);
        step();
        chk("ill_idle_busy", {31'd0, bus.busy}, 32'd0);

        // HALT opcode.
        bus.run = 1'b1;
        step();
        serve(16'hF000, 0);
        step();
        chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        chk("halt_busy", {31'd0, bus.busy}, 32'd0);
        chk("halt_nofault", {31'd0, bus.fault}, 32'd0);
        step();
        step();
        chk("halt_sticky", {31'd0, bus.halted}, 32'd1);
        chk("halt_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("halt_rst", {31'd0, bus.halted}, 32'd0);
        step();

        // Reset mid-EXEC drops everything on that edge.
        serve(16'h2005, 0);
        exec_enter();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.run = 1'b0;
        chk("midrst_fbn", {16'd0, bus.fullBitNum}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_rd", {31'd0, bus.mem_rd}, 32'd0);
        step();
        chk("midrst_idle", {31'd0, bus.busy}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
